// File: rtl/zx_bus_dma.sv
// Z80 bus-master DMA: BUSREQ/BUSACK handshake, then STROBE_CYC+3 cycles per access (SETUP, STROBE, HOLD, NEXT).
// Holds the bus in NEXT while the write FIFO is empty or the read FIFO is full; FIFO ports use valid/ready.

// Show-ahead FIFO, head visible while not empty; a push is accepted when full only alongside a pop.
module zx_bus_dma_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (occ == FULL_OCC);
  assign empty   = (occ == '0);
  assign head    = mem[rd_ptr];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end
endmodule

module zx_bus_dma #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int LEN_W       = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int STROBE_CYC  = 3,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_start,
  input  logic [1:0]        cmd_mode,
  input  logic              cmd_io,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_fill,
  input  logic              cmd_abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  count,
  input  logic [DATA_W-1:0] wf_data,
  input  logic              wf_valid,
  output logic              wf_ready,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_valid,
  input  logic              rf_ready,
  output logic              bus_req_n,
  input  logic              bus_ack_n,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in,
  output logic [3:0]        ctrl_bus
);
  localparam logic [1:0] M_WR   = 2'b00;
  localparam logic [1:0] M_RD   = 2'b01;
  localparam logic [1:0] M_FILL = 2'b10;

  localparam int SW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [SW-1:0] STB_LAST = SW'(STROBE_CYC - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SETUP, S_STROBE, S_HOLD, S_NEXT, S_RELEASE, S_DONE
  } state_t;

  state_t            state;
  logic [1:0]        mode_q;
  logic              io_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] fill_q;
  logic [ADDR_W-1:0] cur_addr;
  logic              abort_seen;
  logic [TW-1:0]     tmo;
  logic [SW-1:0]     stb_cnt;
  logic [DATA_W-1:0] rd_hold;
  logic              ack_s1;
  logic              ack_s2;

  logic [DATA_W-1:0] wf_head;
  logic              wf_full, wf_empty, rf_full, rf_empty;
  logic              wf_pop, rf_push;
  logic              can_go, abort_hit, finish, launch;

  assign wf_ready  = !wf_full;
  assign rf_valid  = !rf_empty;
  assign can_go    = (mode_q == M_WR) ? !wf_empty :
                     (mode_q == M_RD) ? !rf_full  : 1'b1;
  assign abort_hit = cmd_abort || abort_seen;
  assign finish    = (count == len_q) || abort_hit;
  // An access may only begin when its data (write) or its landing slot (read) is guaranteed.
  assign launch    = ((state == S_REQ)  && !abort_hit && !ack_s2 && can_go) ||
                     ((state == S_NEXT) && !finish && can_go);
  assign wf_pop    = launch && (mode_q == M_WR);
  assign rf_push   = (state == S_HOLD) && (mode_q == M_RD);

  zx_bus_dma_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_wf (
    .clk(clk_clk), .rst(reset_reset),
    .push(wf_valid && !wf_full), .push_dat(wf_data),
    .pop(wf_pop), .head(wf_head), .full(wf_full), .empty(wf_empty)
  );

  zx_bus_dma_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rf (
    .clk(clk_clk), .rst(reset_reset),
    .push(rf_push), .push_dat(rd_hold),
    .pop(rf_ready && !rf_empty), .head(rf_data), .full(rf_full), .empty(rf_empty)
  );

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state      <= S_IDLE;
      mode_q     <= M_WR;
      io_q       <= 1'b0;
      len_q      <= '0;
      fill_q     <= '0;
      cur_addr   <= '0;
      abort_seen <= 1'b0;
      tmo        <= '0;
      stb_cnt    <= '0;
      rd_hold    <= '0;
      ack_s1     <= 1'b1;
      ack_s2     <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      count      <= '0;
      bus_req_n  <= 1'b1;
      address    <= '0;
      data_out   <= '0;
      data_oe    <= 1'b0;
      ctrl_bus   <= 4'b1111;
    end else begin
      ack_s1 <= bus_ack_n;
      ack_s2 <= ack_s1;
      done   <= 1'b0;
      if (busy && cmd_abort) abort_seen <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (cmd_start) begin
            mode_q     <= cmd_mode;
            io_q       <= cmd_io;
            len_q      <= cmd_len;
            fill_q     <= cmd_fill;
            cur_addr   <= cmd_addr;
            count      <= '0;
            error      <= 1'b0;
            abort_seen <= 1'b0;
            if (cmd_mode == 2'b11) begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end else if (cmd_len == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              busy      <= 1'b1;
              bus_req_n <= 1'b0;
              tmo       <= '0;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (abort_hit) begin
            bus_req_n <= 1'b1;
            state     <= S_RELEASE;
          end else if (!ack_s2) begin
            state <= launch ? S_SETUP : S_NEXT;
          end else if ((ACK_TIMEOUT != 0) && (tmo == TMO_LAST)) begin
            error     <= 1'b1;
            bus_req_n <= 1'b1;
            state     <= S_RELEASE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_SETUP: begin
          ctrl_bus <= {io_q, !io_q, mode_q != M_RD, mode_q == M_RD};
          stb_cnt  <= '0;
          state    <= S_STROBE;
        end
        S_STROBE: begin
          if (stb_cnt == STB_LAST) begin
            ctrl_bus <= 4'b1111;
            rd_hold  <= data_in;
            state    <= S_HOLD;
          end else begin
            stb_cnt <= stb_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          data_oe  <= 1'b0;
          count    <= count + 1'b1;
          cur_addr <= cur_addr + 1'b1;
          state    <= S_NEXT;
        end
        S_NEXT: begin
          if (finish) begin
            bus_req_n <= 1'b1;
            state     <= S_RELEASE;
          end else if (launch) begin
            state <= S_SETUP;
          end
        end
        S_RELEASE: begin
          if (ack_s2) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (launch) begin
        address <= cur_addr;
        if (mode_q == M_WR) begin
          data_out <= wf_head;
          data_oe  <= 1'b1;
        end else if (mode_q == M_FILL) begin
          data_out <= fill_q;
          data_oe  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_zx_bus_dma.sv
// Directed bench for zx_bus_dma: Z80 ack model, strobe monitor, hand-computed expectations.
module tb_zx_bus_dma;
  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        cmd_start = 1'b0;
  logic [1:0]  cmd_mode = 2'b00;
  logic        cmd_io = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic [7:0]  cmd_fill = '0;
  logic        cmd_abort = 1'b0;
  logic        busy, done, error;
  logic [15:0] count;
  logic [7:0]  wf_data = '0;
  logic        wf_valid = 1'b0;
  logic        wf_ready;
  logic [7:0]  rf_data;
  logic        rf_valid;
  logic        rf_ready = 1'b0;
  logic        bus_req_n;
  logic        bus_ack_n = 1'b1;
  logic [15:0] address;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in;
  logic [3:0]  ctrl_bus;

  logic        ack_en = 1'b1;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;

  logic [15:0] acc_addr[$];
  logic [7:0]  acc_data[$];
  logic [3:0]  acc_ctrl[$];
  logic        acc_oe[$];
  int          acc_len[$];
  int          acc_t[$];
  logic        in_stb = 1'b0;
  int          stb_len = 0;

  zx_bus_dma #(
    .ADDR_W(16), .DATA_W(8), .LEN_W(16), .FIFO_DEPTH(16),
    .STROBE_CYC(3), .ACK_TIMEOUT(16)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .cmd_start(cmd_start), .cmd_mode(cmd_mode), .cmd_io(cmd_io),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_fill(cmd_fill), .cmd_abort(cmd_abort),
    .busy(busy), .done(done), .error(error), .count(count),
    .wf_data(wf_data), .wf_valid(wf_valid), .wf_ready(wf_ready),
    .rf_data(rf_data), .rf_valid(rf_valid), .rf_ready(rf_ready),
    .bus_req_n(bus_req_n), .bus_ack_n(bus_ack_n),
    .address(address), .data_out(data_out), .data_oe(data_oe),
    .data_in(data_in), .ctrl_bus(ctrl_bus)
  );

  always #5 clk_clk = ~clk_clk;
  always @(posedge clk_clk) cyc++;

  // Memory/IO model returns the low address byte; Z80 grants the bus one half-cycle after a request.
  assign data_in = address[7:0];
  always @(negedge clk_clk) bus_ack_n = ack_en ? bus_req_n : 1'b1;

  always @(negedge clk_clk) begin
    if (ctrl_bus[1:0] != 2'b11) begin
      if (!in_stb) begin
        acc_addr.push_back(address);
        acc_data.push_back(data_out);
        acc_ctrl.push_back(ctrl_bus);
        acc_oe.push_back(data_oe);
        acc_t.push_back(cyc);
        stb_len = 0;
      end
      in_stb = 1'b1;
      stb_len++;
    end else if (in_stb) begin
      acc_len.push_back(stb_len);
      in_stb = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic clr_mon();
    acc_addr.delete(); acc_data.delete(); acc_ctrl.delete();
    acc_oe.delete(); acc_len.delete(); acc_t.delete();
  endtask

  task automatic start(input logic [1:0] m, input logic io, input logic [15:0] a,
                       input logic [15:0] l, input logic [7:0] f);
    cmd_mode = m; cmd_io = io; cmd_addr = a; cmd_len = l; cmd_fill = f;
    cmd_start = 1'b1;
    @(negedge clk_clk);
    cmd_start = 1'b0;
  endtask

  task automatic push_wf(input logic [7:0] v);
    wf_data = v; wf_valid = 1'b1;
    @(negedge clk_clk);
    wf_valid = 1'b0;
  endtask

  task automatic pop_rf(input string tag, input logic [7:0] exp);
    check({tag, "_vld"}, rf_valid, 1);
    check({tag, "_dat"}, rf_data, exp);
    rf_ready = 1'b1;
    @(negedge clk_clk);
    rf_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk_clk);
      n++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic wait_acc(input string tag, input int nacc, input int budget);
    int n = 0;
    while (acc_addr.size() < nacc && n < budget) begin
      @(negedge clk_clk);
      n++;
    end
    check({tag, "_reached"}, acc_addr.size(), nacc);
  endtask

  task automatic check_acc(input string tag, input int i, input logic [15:0] a,
                           input logic [7:0] d, input logic [3:0] c, input logic wr);
    if (acc_addr.size() > i) begin
      check({tag, "_addr"}, acc_addr[i], a);
      check({tag, "_ctrl"}, acc_ctrl[i], c);
      check({tag, "_oe"}, acc_oe[i], wr);
      if (wr) check({tag, "_data"}, acc_data[i], d);
    end else begin
      check({tag, "_missing"}, acc_addr.size(), i + 1);
    end
    if (acc_len.size() > i) check({tag, "_len"}, acc_len[i], 3);
    else check({tag, "_len_missing"}, acc_len.size(), i + 1);
  endtask

  initial begin
    logic [7:0]  wr_vals [4];
    logic [15:0] rd_addr [3];
    logic [7:0]  rd_exp  [3];
    logic [15:0] fl_addr [4];
    logic [7:0]  st_vals [8];
    int n, ndone, bad;
    wr_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    rd_addr = '{16'h00FE, 16'h00FF, 16'h0100};
    rd_exp  = '{8'hFE, 8'hFF, 8'h00};
    fl_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    st_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_count", count, 0);
    check("rst_req", bus_req_n, 1);
    check("rst_addr", address, 0);
    check("rst_dout", data_out, 0);
    check("rst_oe", data_oe, 0);
    check("rst_ctrl", ctrl_bus, 4'hF);
    check("rst_wf_ready", wf_ready, 1);
    check("rst_rf_valid", rf_valid, 0);
    reset_reset = 1'b0;
    tick(2);

    // Memory write from FIFO
    clr_mon();
    for (int i = 0; i < 4; i++) push_wf(wr_vals[i]);
    start(2'b00, 1'b0, 16'h4000, 16'd4, 8'h00);
    check("wr_busy", busy, 1);
    check("wr_req", bus_req_n, 0);
    wait_done("wr", 200);
    check("wr_count", count, 4);
    check("wr_error", error, 0);
    check("wr_busy_end", busy, 0);
    check("wr_nacc", acc_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      check_acc($sformatf("wr%0d", i), i, 16'h4000 + 16'(i), wr_vals[i], 4'b0110, 1'b1);
    if (acc_t.size() > 1) check("wr_access_period", acc_t[1] - acc_t[0], 6);
    tick(1);
    check("wr_done_pulse", done, 0);
    check("wr_release", bus_req_n, 1);
    check("wr_oe_off", data_oe, 0);

    // I/O read into FIFO, address crosses 0x00FF
    clr_mon();
    start(2'b01, 1'b1, 16'h00FE, 16'd3, 8'h00);
    wait_done("rd", 200);
    check("rd_count", count, 3);
    check("rd_nacc", acc_addr.size(), 3);
    for (int i = 0; i < 3; i++)
      check_acc($sformatf("rd%0d", i), i, rd_addr[i], 8'h00, 4'b1001, 1'b0);
    tick(1);
    for (int i = 0; i < 3; i++) pop_rf($sformatf("rf%0d", i), rd_exp[i]);
    check("rd_rf_drained", rf_valid, 0);

    // Constant fill wrapping at the top of memory
    clr_mon();
    start(2'b10, 1'b0, 16'hFFFE, 16'd4, 8'hAA);
    wait_done("fill", 200);
    check("fill_count", count, 4);
    check("fill_nacc", acc_addr.size(), 4);
    for (int i = 0; i < 4; i++)
      check_acc($sformatf("fill%0d", i), i, fl_addr[i], 8'hAA, 4'b0110, 1'b1);
    tick(1);

    // Zero length: done next cycle without touching the bus
    start(2'b10, 1'b0, 16'h1000, 16'd0, 8'h00);
    check("len0_done", done, 1);
    check("len0_req", bus_req_n, 1);
    check("len0_busy", busy, 0);
    tick(1);
    check("len0_done_pulse", done, 0);

    // Reserved mode
    start(2'b11, 1'b0, 16'h1000, 16'd5, 8'h00);
    check("rsv_done", done, 1);
    check("rsv_error", error, 1);
    check("rsv_req", bus_req_n, 1);
    tick(1);

    // Bus acknowledge never arrives
    clr_mon();
    ack_en = 1'b0;
    start(2'b10, 1'b0, 16'h2000, 16'd2, 8'h5A);
    check("to_error_cleared", error, 0);
    check("to_req", bus_req_n, 0);
    n = 0;
    while (!error && n < 100) begin
      tick(1);
      n++;
    end
    check("to_cycles", n, 16);
    check("to_req_released", bus_req_n, 1);
    ndone = 0;
    repeat (10) begin
      if (done) ndone++;
      tick(1);
    end
    check("to_done_pulses", ndone, 1);
    check("to_count", count, 0);
    check("to_error_sticky", error, 1);
    check("to_nacc", acc_addr.size(), 0);
    ack_en = 1'b1;
    tick(2);

    // Write stalls on an empty FIFO, then abort during the fifth access
    clr_mon();
    push_wf(st_vals[0]);
    push_wf(st_vals[1]);
    start(2'b00, 1'b0, 16'h8000, 16'd8, 8'h00);
    n = 0;
    while (acc_len.size() < 2 && n < 200) begin
      tick(1);
      n++;
    end
    check("st_two_done", acc_len.size(), 2);
    bad = 0;
    repeat (20) begin
      tick(1);
      if (ctrl_bus !== 4'hF || bus_req_n !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("st_bus_held_idle", bad, 0);
    check("st_count_stall", count, 2);
    for (int i = 2; i < 8; i++) push_wf(st_vals[i]);
    wait_acc("st_acc5", 5, 200);
    cmd_abort = 1'b1;
    tick(1);
    cmd_abort = 1'b0;
    wait_done("st", 200);
    check("st_count", count, 5);
    check("st_error", error, 0);
    check("st_nacc", acc_addr.size(), 5);
    check_acc("st4", 4, 16'h8004, 8'h55, 4'b0110, 1'b1);
    tick(1);

    // Reset in the middle of a read strobe
    clr_mon();
    start(2'b01, 1'b0, 16'h0010, 16'd2, 8'h00);
    wait_acc("rs_acc2", 2, 200);
    check("rs_rf_pre", rf_valid, 1);
    check("rs_in_strobe", ctrl_bus, 4'b0101);
    reset_reset = 1'b1;
    #1;
    check("rs_ctrl", ctrl_bus, 4'hF);
    check("rs_req", bus_req_n, 1);
    check("rs_oe", data_oe, 0);
    check("rs_busy", busy, 0);
    check("rs_rf_empty", rf_valid, 0);
    check("rs_count", count, 0);
    tick(2);
    reset_reset = 1'b0;
    tick(3);

    // Write FIFO was flushed by reset: a write must stall with no strobes until aborted
    clr_mon();
    start(2'b00, 1'b0, 16'h3000, 16'd1, 8'h00);
    tick(30);
    check("rs_wf_nacc", acc_addr.size(), 0);
    check("rs_wf_held", bus_req_n, 0);
    cmd_abort = 1'b1;
    tick(1);
    cmd_abort = 1'b0;
    wait_done("rs_wf", 200);
    check("rs_wf_count", count, 0);
    check("rs_wf_error", error, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its end, tests=%0d", n_tests);
    $fatal(1, "watchdog expired");
  end
endmodule
